// File: rtl/lite_bus_pkg.sv
// Shared bus definitions: response-owner tag and the memory-mapped I/O window map.
package lite_bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_e;

    localparam logic [11:0] IO_BASE_HI = 12'hfff;
    localparam logic [15:0] SW_ADDR    = 16'hfff0;
    localparam logic [15:0] SEG_ADDR   = 16'hfffa;

    // True when a byte address falls in the 16-byte I/O window at the top of the map.
    function automatic logic is_io(input logic [15:0] addr);
        return addr[15:4] == IO_BASE_HI;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (switches).
module sync_2ff #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    // Next state: shift the input one stage per edge.
    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
    end

    // Synchronizer stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data ports,
// and decodes the switch / 7-segment I/O window.
module mem_port_arbiter
    import lite_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [6:0]  SEG_RESET  = 7'h00
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [15:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [15:0]       d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [15:0]       d_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,

    input  logic [1:0]        sw_in,
    output logic [6:0]        seg_out
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    owner_e           owner_q, owner_d;
    logic             io_q, io_d;         // response comes from io_data_q, not the RAM
    logic             we_q, we_d;         // data response is a store completion
    logic [15:0]      io_data_q, io_data_d;
    logic [15:0]      if_hold_q, if_hold_d;
    logic [15:0]      d_hold_q, d_hold_d;
    logic [6:0]       seg_q, seg_d;

    logic [1:0]       sw_sync;
    logic             fetch_forced;
    logic [15:0]      gnt_addr;
    logic             gnt_io;
    logic [15:0]      resp_data;

    sync_2ff #(
        .W (2)
    ) u_sw_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (sw_in),
        .q_o   (sw_sync)
    );

    // Arbitration, address decode and RAM strobe for the granted requester.
    always_comb begin
        fetch_forced = (starve_q == CNT_W'(STARVE_MAX));
        d_gnt        = d_req && !(if_req && fetch_forced);
        if_gnt       = if_req && !d_gnt;
        gnt_addr     = d_gnt ? d_addr : if_addr;
        gnt_io       = is_io(gnt_addr);
        ram_en       = (if_gnt || d_gnt) && !gnt_io;
        ram_we       = d_gnt && d_we && !gnt_io;
        ram_addr     = gnt_addr[ADDR_W:1];
        ram_wdata    = d_wdata;

        starve_d = starve_q;
        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (!fetch_forced) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Response tagging, I/O read capture and 7-segment register update at the grant edge.
    always_comb begin
        owner_d   = OWN_NONE;
        io_d      = gnt_io;
        we_d      = d_gnt && d_we;
        io_data_d = '0;
        seg_d     = seg_q;

        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt) begin
            owner_d = OWN_D;
        end

        // Fetches from the I/O window always return zero.
        if (d_gnt && !d_we) begin
            if (gnt_addr == SW_ADDR) begin
                io_data_d = {14'b0, sw_sync};
            end else if (gnt_addr == SEG_ADDR) begin
                io_data_d = {9'b0, seg_q};
            end
        end

        if (d_gnt && d_we && gnt_addr == SEG_ADDR) begin
            seg_d = d_wdata[6:0];
        end
    end

    // Response outputs: valid one cycle after grant, read data held between responses.
    always_comb begin
        resp_data = io_q ? io_data_q : ram_rdata;
        if_valid  = (owner_q == OWN_IF);
        d_valid   = (owner_q == OWN_D);
        if_rdata  = if_valid ? resp_data : if_hold_q;
        d_rdata   = (d_valid && !we_q) ? resp_data : d_hold_q;
        if_hold_d = if_rdata;
        d_hold_d  = d_rdata;
        seg_out   = seg_q;
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q  <= '0;
            owner_q   <= OWN_NONE;
            io_q      <= 1'b0;
            we_q      <= 1'b0;
            io_data_q <= '0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
            seg_q     <= SEG_RESET;
        end else begin
            starve_q  <= starve_d;
            owner_q   <= owner_d;
            io_q      <= io_d;
            we_q      <= we_d;
            io_data_q <= io_data_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
            seg_q     <= seg_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: RAM model, behavioural reference and directed tests.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic [15:0] if_rdata, d_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [1:0]  sw_in;
    logic [6:0]  seg_out;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (8),
        .STARVE_MAX (STARVE_MAX),
        .SEG_RESET  (7'h00)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .seg_out   (seg_out)
    );

    always #5 clock = ~clock;

    // External single-port RAM with one-cycle read latency.
    logic [15:0] ram_mem [256];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int          m_starve;
    bit          m_if_pend, m_d_pend;
    logic [15:0] m_if_rd, m_d_rd;
    logic [6:0]  m_seg;
    logic [1:0]  m_s1, m_sync;
    logic [15:0] ref_mem [256];

    // Reference model and per-cycle comparison, sampled mid-cycle.
    always @(negedge clock) begin
        bit          eg_if, eg_d, io;
        logic [15:0] a, val;
        if (reset) begin
            chk("rst_if_valid", if_valid, 0);
            chk("rst_d_valid", d_valid, 0);
            chk("rst_seg", seg_out, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            m_starve = 0; m_if_pend = 0; m_d_pend = 0;
            m_if_rd = 0; m_d_rd = 0; m_seg = 0; m_s1 = 0; m_sync = 0;
        end else begin
            eg_d  = d_req && !(if_req && m_starve == STARVE_MAX);
            eg_if = if_req && !eg_d;
            chk("if_gnt", if_gnt, eg_if);
            chk("d_gnt", d_gnt, eg_d);
            chk("if_valid", if_valid, m_if_pend);
            chk("d_valid", d_valid, m_d_pend);
            chk("if_rdata", if_rdata, m_if_rd);
            chk("d_rdata", d_rdata, m_d_rd);
            chk("seg_out", seg_out, m_seg);

            a  = eg_d ? d_addr : if_addr;
            io = (a >= 16'hfff0);
            if (eg_if || eg_d) begin
                chk("ram_en", ram_en, !io);
                if (!io) begin
                    chk("ram_addr", ram_addr, a[8:1]);
                    chk("ram_we", ram_we, eg_d && d_we);
                    if (eg_d && d_we) chk("ram_wdata", ram_wdata, d_wdata);
                end
            end else begin
                chk("ram_en_idle", ram_en, 0);
            end

            if (io) begin
                if (eg_d && a == 16'hfff0)      val = {14'b0, m_sync};
                else if (eg_d && a == 16'hfffa) val = {9'b0, m_seg};
                else                            val = 16'h0000;
            end else begin
                val = ref_mem[a[8:1]];
            end
            m_if_pend = eg_if;
            m_d_pend  = eg_d;
            if (eg_if) m_if_rd = val;
            if (eg_d && !d_we) m_d_rd = val;
            if (eg_d && d_we) begin
                if (!io) ref_mem[a[8:1]] = d_wdata;
                else if (a == 16'hfffa) m_seg = d_wdata[6:0];
            end
            if (eg_if || !if_req) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
            m_sync = m_s1;
            m_s1   = sw_in;
        end
    end

    logic       g_ram_en, g_ram_we;
    logic [7:0] g_ram_addr;

    // Called at posedge+1; returns at posedge+1 of the response cycle.
    task automatic req_if(input logic [15:0] a, output int waits);
        waits   = 0;
        if_req  = 1'b1;
        if_addr = a;
        @(negedge clock);
        while (!if_gnt && waits < 50) begin
            waits++;
            @(negedge clock);
        end
        chk("if_gnt_wait", if_gnt, 1);
        g_ram_en = ram_en; g_ram_we = ram_we; g_ram_addr = ram_addr;
        @(posedge clock); #1;
        if_req = 1'b0;
    endtask

    task automatic req_d(input logic we, input logic [15:0] a, input logic [15:0] wd);
        int waits = 0;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        @(negedge clock);
        while (!d_gnt && waits < 50) begin
            waits++;
            @(negedge clock);
        end
        chk("d_gnt_wait", d_gnt, 1);
        g_ram_en = ram_en; g_ram_we = ram_we; g_ram_addr = ram_addr;
        @(posedge clock); #1;
        d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        int          w, late;
        logic [9:0]  seq;
        int          d_cnt;
        if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; sw_in = 2'b00;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'h1000 + 16'(i);
            ref_mem[i] = 16'h1000 + 16'(i);
        end
        repeat (3) @(posedge clock);
        @(negedge clock); #2 reset = 1'b0;
        @(posedge clock); #1;

        // Fetch stream: a grant every cycle, data one cycle later.
        late = 0;
        for (int a = 0; a <= 16; a += 2) begin
            req_if(16'(a), w);
            if (w != 0) late++;
        end
        chk("fetch_every_cycle", late, 0);
        chk("fetch_last_valid", if_valid, 1);
        chk("fetch_last_rdata", if_rdata, 16'h1008);

        // Store then load through RAM.
        req_d(1'b1, 16'h0020, 16'h1234);
        chk("st_ram_addr", g_ram_addr, 8'h10);
        chk("st_ram_we", g_ram_we, 1);
        chk("st_done", d_valid, 1);
        req_d(1'b0, 16'h0020, 16'h0000);
        chk("ld_valid", d_valid, 1);
        chk("ld_rdata", d_rdata, 16'h1234);

        // 7-segment register.
        req_d(1'b1, 16'hfffa, 16'h006d);
        chk("seg_ram_en", g_ram_en, 0);
        chk("seg_value", seg_out, 7'h6d);
        req_d(1'b0, 16'hfffa, 16'h0000);
        chk("seg_read", d_rdata, 16'h006d);

        // Fetch from the I/O window returns zero without touching RAM.
        req_if(16'hfff0, w);
        chk("io_fetch_ram_en", g_ram_en, 0);
        chk("io_fetch_valid", if_valid, 1);
        chk("io_fetch_rdata", if_rdata, 16'h0000);

        // Switch synchronizer latency.
        sw_in = 2'b01;
        @(posedge clock); #1;
        req_d(1'b0, 16'hfff0, 16'h0000);
        chk("sw_early", d_rdata, 16'h0000);
        sw_in = 2'b00;
        repeat (4) @(posedge clock); #1;
        sw_in = 2'b01;
        repeat (3) @(posedge clock); #1;
        req_d(1'b0, 16'hfff0, 16'h0000);
        chk("sw_late", d_rdata, 16'h0001);

        // Contention: four data grants then one forced fetch grant, repeating.
        if_req = 1; if_addr = 16'h0002;
        d_req = 1; d_we = 0; d_addr = 16'h0020;
        d_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            seq[i] = if_gnt;
            if (d_gnt) d_cnt++;
        end
        @(posedge clock); #1;
        if_req = 0; d_req = 0;
        chk("starve_pattern", seq, 10'b10_0001_0000);
        chk("starve_d_count", d_cnt, 8);
        @(posedge clock); #1;

        // Reset while a load is in flight.
        d_req = 1; d_we = 0; d_addr = 16'h0020;
        @(negedge clock); #2 reset = 1'b1;
        d_req = 0;
        @(posedge clock); #1;
        chk("rst_drop_valid", d_valid, 0);
        chk("rst_seg_value", seg_out, 7'h00);
        chk("rst_rdata_clear", d_rdata, 16'h0000);
        @(negedge clock); #2 reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_no_valid", d_valid, 0);
        req_d(1'b0, 16'h0020, 16'h0000);
        chk("post_rst_ld", d_rdata, 16'h1234);

        repeat (3) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
